// File: rtl/adder_arbiter_pkg.sv
// Shared types and widths for the adder arbiter slice.
package adder_arbiter_pkg;

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;

  localparam int ADDER_W = 32;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle around the shared adder; slave is the arbiter's view.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int REQ_IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid_i;
  logic [NUM_REQ-1:0]              req_ready_o;
  logic [NUM_REQ-1:0][ADDER_W-1:0] req_op1_i;
  logic [NUM_REQ-1:0][ADDER_W-1:0] req_op2_i;
  logic                            rsp_valid_o;
  logic [REQ_IDX_W-1:0]            rsp_id_o;
  logic [ADDER_W-1:0]              rsp_sum_o;
  logic                            rsp_ready_i;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o
  );

endinterface

// File: rtl/adder_arbiter_adder.sv
// Plain 32-bit adder shared by all requesters; combinational, carry-out dropped.
module adder
  import adder_arbiter_pkg::*;
(
  input  logic [ADDER_W-1:0] adder_op1_i,
  input  logic [ADDER_W-1:0] adder_op2_i,
  output logic [ADDER_W-1:0] sum_o
);

  assign sum_o = adder_op1_i + adder_op2_i;

endmodule

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin pick: first valid requester after last_grant_i, gated by en_i.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 en_i,
  input  logic [REQ_IDX_W-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [REQ_IDX_W-1:0] gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [REQ_IDX_W-1:0] cand;
      cand = REQ_IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between NUM_REQ requesters; result registered one cycle after accept.
// A full, undrained result slot blocks all grants; a drain frees the slot in the same cycle.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  adder_arbiter_if.slave  bus
);

  localparam int REQ_IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [ADDER_W-1:0]   sum_q, sum_d;
  logic [REQ_IDX_W-1:0] id_q, id_d;
  logic [REQ_IDX_W-1:0] last_q, last_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [REQ_IDX_W-1:0] gnt_idx;
  logic [ADDER_W-1:0]   op1_mux, op2_mux, sum_w;
  logic                 drain, slot_free, accept;

  assign drain     = (state_q == ARB_FULL) & bus.rsp_ready_i;
  // Grants are suppressed during reset so nothing is accepted and then lost.
  assign slot_free = ((state_q == ARB_EMPTY) | drain) & ~rst_i;
  assign accept    = |(bus.req_valid_i & gnt);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W)) u_rr (
    .req_i        (bus.req_valid_i),
    .en_i         (slot_free),
    .last_grant_i (last_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  assign op1_mux = bus.req_op1_i[gnt_idx];
  assign op2_mux = bus.req_op2_i[gnt_idx];

  adder u_adder (
    .adder_op1_i (op1_mux),
    .adder_op2_i (op2_mux),
    .sum_o       (sum_w)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_EMPTY: if (accept) state_d = ARB_FULL;
      ARB_FULL:  if (drain && !accept) state_d = ARB_EMPTY;
      default:   state_d = ARB_EMPTY;
    endcase
    if (accept) begin
      sum_d  = sum_w;
      id_d   = gnt_idx;
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      last_q  <= REQ_IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.rsp_valid_o = (state_q == ARB_FULL);
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_sum_o   = sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scenarios for adder_arbiter with hand-computed expected values.
module tb_adder_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  adder_arbiter_if #(.NUM_REQ(4)) bus ();

  adder_arbiter #(.NUM_REQ(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic [1:0] id,
                         input logic [31:0] sum);
    checks++;
    if (bus.rsp_valid_o !== v || bus.rsp_id_o !== id || bus.rsp_sum_o !== sum) begin
      errors++;
      $display("FAIL %s: got valid=%0b id=%0d sum=%h, want valid=%0b id=%0d sum=%h",
               name, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_sum_o, v, id, sum);
    end
  endtask

  task automatic chk_rdy(input string name, input logic [3:0] exp);
    checks++;
    if (bus.req_ready_o !== exp) begin
      errors++;
      $display("FAIL %s: got req_ready=%b, want %b", name, bus.req_ready_o, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 4'b0001;
    bus.rsp_ready_i = 1'b1;
    bus.req_op1_i   = '0;
    bus.req_op2_i   = '0;
    step();
    step();
    chk_rsp("reset_rsp", 1'b0, 2'd0, 32'd0);
    chk_rdy("reset_no_grant", 4'b0000);
    rst = 1'b0;
    bus.req_valid_i = '0;
    #1;
    chk_rdy("idle_no_grant", 4'b0000);
  endtask

  task automatic test_basic();
    bus.req_valid_i  = 4'b0001;
    bus.req_op1_i[0] = 32'd5;
    bus.req_op2_i[0] = 32'd7;
    bus.rsp_ready_i  = 1'b1;
    #1;
    chk_rdy("basic_grant", 4'b0001);
    step();
    bus.req_valid_i = '0;
    #1;
    chk_rsp("basic_rsp", 1'b1, 2'd0, 32'd12);
    step();
    chk_rsp("basic_drained", 1'b0, 2'd0, 32'd12);
  endtask

  task automatic test_wrap();
    // Pointer is 0 here, so requester 1 is searched first.
    bus.req_valid_i  = 4'b0010;
    bus.req_op1_i[1] = 32'hFFFF_FFFF;
    bus.req_op2_i[1] = 32'h0000_0002;
    #1;
    chk_rdy("wrap_grant", 4'b0010);
    step();
    bus.req_valid_i = '0;
    #1;
    chk_rsp("wrap_rsp", 1'b1, 2'd1, 32'h0000_0001);
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0]  order [5];
    logic [31:0] sums  [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sums  = '{32'h0000_1000, 32'h0000_2001, 32'h0000_3002, 32'h0000_4003};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_op1_i[i] = 32'h1000 * (i + 1);
      bus.req_op2_i[i] = i;
    end
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_rdy($sformatf("rr_grant%0d", k), 4'b0001 << order[k]);
      if (k > 0)
        chk_rsp($sformatf("rr_rsp%0d", k), 1'b1, order[k-1], sums[order[k-1]]);
      step();
    end
    bus.req_valid_i = '0;
    #1;
    chk_rsp("rr_rsp_last", 1'b1, order[4], sums[order[4]]);
    step();
    chk_rsp("rr_drained", 1'b0, order[4], sums[order[4]]);
  endtask

  task automatic test_backpressure();
    // Pointer is 0: requester 0 wins a lone request via the wrap.
    bus.req_valid_i  = 4'b0001;
    bus.req_op1_i[0] = 32'd10;
    bus.req_op2_i[0] = 32'd20;
    bus.rsp_ready_i  = 1'b0;
    step();
    bus.req_valid_i  = 4'b0100;
    bus.req_op1_i[2] = 32'd40;
    bus.req_op2_i[2] = 32'd2;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_rdy($sformatf("bp_no_grant%0d", k), 4'b0000);
      chk_rsp($sformatf("bp_hold%0d", k), 1'b1, 2'd0, 32'd30);
      step();
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    chk_rdy("bp_drain_grant", 4'b0100);
    step();
    bus.req_valid_i = '0;
    #1;
    chk_rsp("bp_new_rsp", 1'b1, 2'd2, 32'd42);
    step();
  endtask

  task automatic test_pointer();
    // Pointer is 2: requester 3 goes next, leaving the pointer at 3.
    bus.req_valid_i  = 4'b1000;
    bus.req_op1_i[3] = 32'd1;
    bus.req_op2_i[3] = 32'd1;
    bus.rsp_ready_i  = 1'b1;
    #1;
    chk_rdy("ptr_grant3", 4'b1000);
    step();
    bus.req_valid_i  = 4'b0010;
    bus.req_op1_i[1] = 32'd100;
    bus.req_op2_i[1] = 32'd11;
    #1;
    chk_rdy("ptr_grant1", 4'b0010);
    step();
    bus.req_valid_i  = 4'b0011;
    bus.req_op1_i[0] = 32'd7;
    bus.req_op2_i[0] = 32'd8;
    #1;
    chk_rdy("ptr_grant0_over1", 4'b0001);
    chk_rsp("ptr_rsp1", 1'b1, 2'd1, 32'd111);
    step();
    bus.req_valid_i = '0;
    #1;
    chk_rsp("ptr_rsp0", 1'b1, 2'd0, 32'd15);
    step();
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i  = 4'b0001;
    bus.req_op1_i[0] = 32'd5;
    bus.req_op2_i[0] = 32'd7;
    bus.rsp_ready_i  = 1'b0;
    step();
    chk_rsp("mid_full", 1'b1, 2'd0, 32'd12);
    rst = 1'b1;
    bus.req_valid_i = '0;
    step();
    chk_rsp("mid_reset_rsp", 1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.rsp_ready_i = 1'b1;
    #1;
    chk_rdy("mid_first_grant", 4'b0001);
    step();
    bus.req_valid_i = '0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_pointer();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
